// File: rtl/pc_stack_unit.sv
// Program counter with increment, jump, relative branch and call/return
// through an internal LIFO return stack; sticky overflow/underflow flags.
module pc_stack_unit #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       OFF_W       = 8,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [2:0]                   op,
    input  logic [ADDR_W-1:0]            target,
    input  logic [OFF_W-1:0]             offset,
    input  logic                         clr_err,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            ret_top,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         stk_ovf,
    output logic                         stk_unf
);

    localparam int unsigned       IDX_W   = $clog2(STACK_DEPTH);
    localparam int unsigned       SP_W    = IDX_W + 1;
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_JMP    = 3'b010,
        OP_BRANCH = 3'b011,
        OP_CALL   = 3'b100,
        OP_RET    = 3'b101
    } op_e;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_next;
    logic [SP_W-1:0]   sp_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] off_ext;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] top_entry;
    logic              push_en;
    logic              set_ovf;
    logic              set_unf;

    assign pc_inc    = pc + PC_ONE;
    assign off_ext   = ADDR_W'($signed(offset));
    // Depth is a power of two, so a full stack's low sp bits wrap to 0 and 0-1 lands on the last entry.
    assign top_idx   = sp[IDX_W-1:0] - IDX_W'(1);
    assign top_entry = stack_mem[top_idx];
    assign ret_top   = (sp == '0) ? '0 : top_entry;

    always_comb begin
        pc_next = pc;
        sp_next = sp;
        push_en = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (!stall) begin
            case (op)
                OP_INC:    pc_next = pc_inc;
                OP_JMP:    pc_next = target;
                OP_BRANCH: pc_next = pc_inc + off_ext;
                OP_CALL: begin
                    pc_next = target;
                    if (sp == SP_FULL) begin
                        set_ovf = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_next = sp + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (sp == '0) begin
                        pc_next = RESET_VEC;
                        set_unf = 1'b1;
                    end else begin
                        pc_next = top_entry;
                        sp_next = sp - SP_W'(1);
                    end
                end
                default: pc_next = pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_VEC;
            sp      <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            pc      <= pc_next;
            sp      <= sp_next;
            stk_ovf <= set_ovf | (stk_ovf & ~clr_err);
            stk_unf <= set_unf | (stk_unf & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp[IDX_W-1:0]] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: stimulus queues expected state per
// clock edge, a monitor pops and compares after each rising edge.
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] target = '0;
    logic [7:0] offset = '0;
    logic       clr_err = 1'b0;
    logic [7:0] pc;
    logic [7:0] ret_top;
    logic [2:0] sp;
    logic       stk_ovf;
    logic       stk_unf;

    typedef struct {
        int         idx;
        logic [7:0] pc;
        logic [2:0] sp;
        logic [7:0] top;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JMP = 3'b010,
                           BRA = 3'b011, CALL = 3'b100, RET = 3'b101, RSV = 3'b110;

    pc_stack_unit #(
        .ADDR_W(8),
        .OFF_W(8),
        .STACK_DEPTH(4),
        .RESET_VEC(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .op(op),
        .target(target),
        .offset(offset),
        .clr_err(clr_err),
        .pc(pc),
        .ret_top(ret_top),
        .sp(sp),
        .stk_ovf(stk_ovf),
        .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("pc", e.idx, pc, e.pc);
        chk("sp", e.idx, {5'b0, sp}, {5'b0, e.sp});
        chk("ret_top", e.idx, ret_top, e.top);
        chk("stk_ovf", e.idx, {7'b0, stk_ovf}, {7'b0, e.ovf});
        chk("stk_unf", e.idx, {7'b0, stk_unf}, {7'b0, e.unf});
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next rising edge.
    task automatic step(input logic st, input logic [2:0] o, input logic [7:0] tg, input logic [7:0] off,
                        input logic clr, input logic [7:0] epc, input logic [2:0] esp,
                        input logic [7:0] etop, input logic eovf, input logic eunf);
        exp_t e;
        @(negedge clk);
        stall = st; op = o; target = tg; offset = off; clr_err = clr;
        step_no++;
        e.idx = step_no; e.pc = epc; e.sp = esp; e.top = etop; e.ovf = eovf; e.unf = eunf;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin : stimulus
        exp_t e;
        // asynchronous reset with no clock edge
        #1 rst = 1'b0;
        #1;
        e.idx = 0; e.pc = 8'h00; e.sp = 3'd0; e.top = 8'h00; e.ovf = 1'b0; e.unf = 1'b0;
        chk_all(e);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // increment run
        step(0, INC, 8'h00, 8'h00, 0, 8'h01, 3'd0, 8'h00, 0, 0);
        step(0, INC, 8'h00, 8'h00, 0, 8'h02, 3'd0, 8'h00, 0, 0);
        step(0, INC, 8'h00, 8'h00, 0, 8'h03, 3'd0, 8'h00, 0, 0);
        step(0, INC, 8'h00, 8'h00, 0, 8'h04, 3'd0, 8'h00, 0, 0);
        step(0, INC, 8'h00, 8'h00, 0, 8'h05, 3'd0, 8'h00, 0, 0);
        step(0, CALL, 8'h70, 8'h00, 0, 8'h70, 3'd1, 8'h06, 0, 0);

        // mid-run reset pulse between edges
        @(negedge clk);
        op = HOLD;
        #2 rst = 1'b0;
        #1;
        e.idx = 100; e.pc = 8'h00; e.sp = 3'd0; e.top = 8'h00; e.ovf = 1'b0; e.unf = 1'b0;
        chk_all(e);
        #1 rst = 1'b1;

        // wrap and branch
        step(0, JMP, 8'hFE, 8'h00, 0, 8'hFE, 3'd0, 8'h00, 0, 0);
        step(0, INC, 8'h00, 8'h00, 0, 8'hFF, 3'd0, 8'h00, 0, 0);
        step(0, INC, 8'h00, 8'h00, 0, 8'h00, 3'd0, 8'h00, 0, 0);
        step(0, JMP, 8'h10, 8'h00, 0, 8'h10, 3'd0, 8'h00, 0, 0);
        step(0, BRA, 8'h00, 8'hF0, 0, 8'h01, 3'd0, 8'h00, 0, 0);
        step(0, JMP, 8'h90, 8'h00, 0, 8'h90, 3'd0, 8'h00, 0, 0);
        step(0, BRA, 8'h00, 8'h7F, 0, 8'h10, 3'd0, 8'h00, 0, 0);

        // call / return
        step(0, JMP, 8'h20, 8'h00, 0, 8'h20, 3'd0, 8'h00, 0, 0);
        step(0, CALL, 8'h80, 8'h00, 0, 8'h80, 3'd1, 8'h21, 0, 0);
        step(0, JMP, 8'h85, 8'h00, 0, 8'h85, 3'd1, 8'h21, 0, 0);
        step(0, CALL, 8'hA0, 8'h00, 0, 8'hA0, 3'd2, 8'h86, 0, 0);
        step(0, RET, 8'h00, 8'h00, 0, 8'h86, 3'd1, 8'h21, 0, 0);
        step(0, RET, 8'h00, 8'h00, 0, 8'h21, 3'd0, 8'h00, 0, 0);

        // fill, overflow, unwind
        step(0, CALL, 8'h30, 8'h00, 0, 8'h30, 3'd1, 8'h22, 0, 0);
        step(0, CALL, 8'h40, 8'h00, 0, 8'h40, 3'd2, 8'h31, 0, 0);
        step(0, CALL, 8'h50, 8'h00, 0, 8'h50, 3'd3, 8'h41, 0, 0);
        step(0, CALL, 8'h60, 8'h00, 0, 8'h60, 3'd4, 8'h51, 0, 0);
        step(0, CALL, 8'h55, 8'h00, 0, 8'h55, 3'd4, 8'h51, 1, 0);
        step(0, RET, 8'h00, 8'h00, 0, 8'h51, 3'd3, 8'h41, 1, 0);
        step(0, RET, 8'h00, 8'h00, 0, 8'h41, 3'd2, 8'h31, 1, 0);
        step(0, RET, 8'h00, 8'h00, 0, 8'h31, 3'd1, 8'h22, 1, 0);
        step(0, RET, 8'h00, 8'h00, 0, 8'h22, 3'd0, 8'h00, 1, 0);
        step(0, HOLD, 8'h77, 8'h05, 0, 8'h22, 3'd0, 8'h00, 1, 0);
        step(0, RSV, 8'h77, 8'h05, 0, 8'h22, 3'd0, 8'h00, 1, 0);

        // underflow and sticky flag clearing
        step(0, JMP, 8'h33, 8'h00, 0, 8'h33, 3'd0, 8'h00, 1, 0);
        step(0, HOLD, 8'h00, 8'h00, 1, 8'h33, 3'd0, 8'h00, 0, 0);
        step(0, RET, 8'h00, 8'h00, 0, 8'h00, 3'd0, 8'h00, 0, 1);
        step(0, HOLD, 8'h00, 8'h00, 0, 8'h00, 3'd0, 8'h00, 0, 1);
        step(0, HOLD, 8'h00, 8'h00, 1, 8'h00, 3'd0, 8'h00, 0, 0);
        step(0, RET, 8'h00, 8'h00, 1, 8'h00, 3'd0, 8'h00, 0, 1);
        step(0, HOLD, 8'h00, 8'h00, 0, 8'h00, 3'd0, 8'h00, 0, 1);

        // stall freezes state; clr_err still acts
        step(0, JMP, 8'h20, 8'h00, 0, 8'h20, 3'd0, 8'h00, 0, 1);
        step(1, CALL, 8'h40, 8'h00, 0, 8'h20, 3'd0, 8'h00, 0, 1);
        step(1, CALL, 8'h40, 8'h00, 0, 8'h20, 3'd0, 8'h00, 0, 1);
        step(1, CALL, 8'h40, 8'h00, 1, 8'h20, 3'd0, 8'h00, 0, 0);
        step(0, CALL, 8'h40, 8'h00, 0, 8'h40, 3'd1, 8'h21, 0, 0);
        step(0, RET, 8'h00, 8'h00, 0, 8'h21, 3'd0, 8'h00, 0, 0);

        @(negedge clk);
        op = HOLD; stall = 1'b0; clr_err = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
